// File: rtl/tl_pkg.sv
// Shared definitions for the A/D request/response channel pair.
// A-channel request opcodes, D-channel response opcodes and the
// responder FSM state encoding.
package tl_pkg;

  // A-channel request opcodes
  localparam logic [3:0] TL_A_PUTFULL    = 4'd0;
  localparam logic [3:0] TL_A_PUTPARTIAL = 4'd1;
  localparam logic [3:0] TL_A_GET        = 4'd4;

  // D-channel response opcodes
  localparam logic [3:0] TL_D_ACK     = 4'd0;
  localparam logic [3:0] TL_D_ACKDATA = 4'd1;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } tl_state_e;

  // Both Put flavours write memory the same way (mask-driven)
  function automatic logic tl_is_put(input logic [3:0] op);
    return (op == TL_A_PUTFULL) || (op == TL_A_PUTPARTIAL);
  endfunction

  function automatic logic tl_is_get(input logic [3:0] op);
    return op == TL_A_GET;
  endfunction

endpackage

// File: rtl/tl_mem_array.sv
// Byte-maskable word memory for the responder.
// 2**ADDR_W words of DATA_W bits held in flops, cleared by reset.
// One synchronous byte-masked write port, one combinational read port,
// so a read of the write address in the write cycle returns old data.
module tl_mem_array #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_mask,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage: clear everything on reset, otherwise update enabled bytes only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_mask[b]) begin
          mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/tl_mem_responder.sv
// Responder end of the A/D channel pair backed by a local word memory.
// Accepts one A-channel request at a time, commits writes at the
// acceptance edge and returns the D-channel beat LATENCY cycles later.
// Optional build macro TL_MEM_DERR_EN adds the d_error response bit.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | a_ready high, waiting for a request
// ST_WAIT | request captured, wait counter running down to zero
// ST_RESP | d_valid high, response held until d_ready
module tl_mem_responder
  import tl_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [3:0]            a_opcode,
  input  logic [DATA_W/8-1:0]   a_mask,
  input  logic [ADDR_W-1:0]     a_address,
  input  logic [DATA_W-1:0]     a_data,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [3:0]            d_opcode,
  output logic [DATA_W-1:0]     d_data
`ifdef TL_MEM_DERR_EN
  ,
  output logic                  d_error
`endif
);

  // The counter is preloaded with LATENCY-1 so ST_WAIT lasts exactly
  // LATENCY cycles; LATENCY=0 skips ST_WAIT entirely.
  localparam logic [3:0] WAIT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  tl_state_e           state_q;
  tl_state_e           state_d;
  logic [3:0]          wait_cnt_q;
  logic                accept;
  logic                req_is_put;
  logic                req_is_get;
  logic                mem_wr_en;
  logic [DATA_W-1:0]   mem_rd_data;

  assign req_is_put = tl_is_put(a_opcode);
  assign req_is_get = tl_is_get(a_opcode);
  assign accept     = a_valid && a_ready;
  assign mem_wr_en  = accept && req_is_put;

  tl_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_wr_en),
    .wr_addr (a_address),
    .wr_mask (a_mask),
    .wr_data (a_data),
    .rd_addr (a_address),
    .rd_data (mem_rd_data)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: one transaction in flight, no re-accept in the handshake cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (d_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: a_ready is forced low while reset is held
  always_comb begin
    a_ready = 1'b0;
    d_valid = 1'b0;
    case (state_q)
      ST_IDLE: a_ready = !rst;
      ST_RESP: d_valid = 1'b1;
      default: begin
        a_ready = 1'b0;
        d_valid = 1'b0;
      end
    endcase
  end

  // Wait down-counter: load on acceptance, count toward zero while waiting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
    end else if (accept) begin
      wait_cnt_q <= WAIT_LOAD;
    end else if ((state_q == ST_WAIT) && (wait_cnt_q != 4'd0)) begin
      wait_cnt_q <= wait_cnt_q - 4'd1;
    end
  end

  // Response registers: captured at acceptance with pre-write read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_opcode <= TL_D_ACK;
      d_data   <= '0;
    end else if (accept) begin
      d_opcode <= req_is_get ? TL_D_ACKDATA : TL_D_ACK;
      d_data   <= req_is_get ? mem_rd_data : '0;
    end
  end

`ifdef TL_MEM_DERR_EN
  // An empty-mask Put writes nothing, so it is flagged like an illegal opcode
  logic resp_err;
  assign resp_err = req_is_get ? 1'b0 :
                    req_is_put ? (a_mask == '0) : 1'b1;

  // Error bit registered alongside the rest of the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_error <= 1'b0;
    end else if (accept) begin
      d_error <= resp_err;
    end
  end
`endif

endmodule
